// File: rtl/opb_register_ppc2simulink_sync_pkg.sv
// Shared definitions for the PPC-to-fabric control register: word offsets,
// slave FSM encoding and the OPB byte-lane merge helper.
package opb_register_ppc2simulink_sync_pkg;

  localparam logic CTRL_OFF = 1'b0;
  localparam logic WCNT_OFF = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACK    = 2'b01,
    ST_WAITDS = 2'b10
  } state_e;

  // OPB byte i (BE[i], DBus[8i:8i+7]) lands on user bits [31-8i -: 8].
  function automatic logic [31:0] merge_be(input logic [31:0] old_word,
                                           input logic [0:31] opb_data,
                                           input logic [0:3]  opb_be);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (opb_be[i]) begin
        res[31-8*i -: 8] = opb_data[8*i +: 8];
      end else begin
        res[31-8*i -: 8] = old_word[31-8*i -: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/opb_slave_ack_fsm.sv
// Address decode and IDLE/ACK/WAITDS handshake: one xferAck per select
// assertion, plus the read/write qualifiers and word select for the top level.
module opb_slave_ack_fsm
  import opb_register_ppc2simulink_sync_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR = 32'h01004200,
  parameter logic [31:0] C_HIGHADDR = 32'h010042FF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] abus,
  input  logic        rnw,
  input  logic        select,
  output logic        xfer_ack,
  output logic        do_read,
  output logic        do_write,
  output logic        word_sel
);

  state_e state_r;
  state_e state_next_s;
  logic   hit_s;
  logic   ack_r;
  logic   wr_r;
  logic   sel_r;
  logic   take_s;

  assign hit_s  = select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);
  assign take_s = (state_r == ST_IDLE) && hit_s;

  // Next-state logic; hits are only decoded from IDLE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (hit_s) begin
          state_next_s = ST_ACK;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ACK: begin
        state_next_s = ST_WAITDS;
      end
      ST_WAITDS: begin
        if (!select) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_WAITDS;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State and registered handshake outputs, all valid during the ACK cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      ack_r   <= 1'b0;
      wr_r    <= 1'b0;
      sel_r   <= CTRL_OFF;
    end else begin
      state_r <= state_next_s;
      ack_r   <= (state_next_s == ST_ACK);
      wr_r    <= take_s && !rnw;
      if (take_s) begin
        sel_r <= abus[2];
      end
    end
  end

  // Reads are sampled at the hit edge, so their select comes straight from
  // the bus; writes commit one cycle later using the latched select.
  assign do_read  = take_s && rnw;
  assign do_write = wr_r;
  assign word_sel = (state_r == ST_IDLE) ? abus[2] : sel_r;
  assign xfer_ack = ack_r;

endmodule

// File: rtl/opb_register_ppc2simulink_sync.sv
// OPB slave control register driven by the PowerPC into user logic, with
// byte-enable writes, readback, an update strobe and a saturating write count.
module opb_register_ppc2simulink_sync
  import opb_register_ppc2simulink_sync_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h01004200,
  parameter logic [31:0] C_HIGHADDR   = 32'h010042FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter logic [31:0] C_INIT       = 32'h00000000,
  parameter string       C_FAMILY     = "virtex6"
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
  output logic                    Sl_xferAck,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  output logic [31:0]             user_data_out,
  output logic                    user_data_strobe
);

  localparam string UNUSED_FAMILY = C_FAMILY;

  logic [31:0] abus_s;
  logic        do_read_s;
  logic        do_write_s;
  logic        word_sel_s;
  logic        ack_s;
  logic [31:0] ctrl_r;
  logic [31:0] wcnt_r;
  logic        strobe_r;
  logic [31:0] rdata_r;
  logic [31:0] rword_s;
  logic        unused_s;

  assign abus_s   = OPB_ABus;
  assign unused_s = OPB_seqAddr;

  opb_slave_ack_fsm #(
    .C_BASEADDR (C_BASEADDR),
    .C_HIGHADDR (C_HIGHADDR)
  ) u_fsm (
    .clk      (OPB_Clk),
    .rst_n    (OPB_Rst_n),
    .abus     (abus_s),
    .rnw      (OPB_RNW),
    .select   (OPB_select),
    .xfer_ack (ack_s),
    .do_read  (do_read_s),
    .do_write (do_write_s),
    .word_sel (word_sel_s)
  );

  // Readback word selection.
  always_comb begin
    rword_s = ctrl_r;
    if (word_sel_s == WCNT_OFF) begin
      rword_s = wcnt_r;
    end else begin
      rword_s = ctrl_r;
    end
  end

  // Register file, write counter, strobe and OR-bus read data.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      ctrl_r   <= C_INIT;
      wcnt_r   <= 32'h00000000;
      strobe_r <= 1'b0;
      rdata_r  <= 32'h00000000;
    end else begin
      // Read data lives only in the ACK cycle so the OR-bus stays clean.
      rdata_r  <= do_read_s ? rword_s : 32'h00000000;
      strobe_r <= do_write_s && (word_sel_s == CTRL_OFF);
      if (do_write_s) begin
        if (word_sel_s == CTRL_OFF) begin
          ctrl_r <= merge_be(ctrl_r, OPB_DBus, OPB_BE);
          if (wcnt_r != 32'hFFFFFFFF) begin
            wcnt_r <= wcnt_r + 32'h00000001;
          end
        end else begin
          wcnt_r <= 32'h00000000;
        end
      end
    end
  end

  assign Sl_DBus          = rdata_r;
  assign Sl_xferAck       = ack_s;
  assign Sl_errAck        = 1'b0;
  assign Sl_retry         = 1'b0;
  assign Sl_toutSup       = 1'b0;
  assign user_data_out    = ctrl_r;
  assign user_data_strobe = strobe_r;

endmodule

// File: tb/tb_opb_register_ppc2simulink_sync.sv
// Scoreboard bench for opb_register_ppc2simulink_sync: expected read data is
// queued at request time and compared when xferAck arrives.
module tb_opb_register_ppc2simulink_sync;

  localparam logic [31:0] BASE = 32'h01004200;
  localparam logic [31:0] HIGH = 32'h010042FF;
  localparam logic [31:0] INIT = 32'h00000000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [0:31] OPB_ABus = 32'h0;
  logic [0:3]  OPB_BE = 4'h0;
  logic [0:31] OPB_DBus = 32'h0;
  logic        OPB_RNW = 1'b1;
  logic        OPB_select = 1'b0;
  logic        OPB_seqAddr = 1'b0;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup;
  logic [31:0] user_data_out;
  logic        user_data_strobe;

  int n_cmp = 0;
  int n_err = 0;
  int ack_cnt = 0;
  int strobe_cnt = 0;
  logic mon_en = 1'b0;
  logic [31:0] m_ctrl;
  logic [31:0] m_wcnt;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  opb_register_ppc2simulink_sync dut (
    .OPB_Clk          (clk),
    .OPB_Rst_n        (rst_n),
    .OPB_ABus         (OPB_ABus),
    .OPB_BE           (OPB_BE),
    .OPB_DBus         (OPB_DBus),
    .OPB_RNW          (OPB_RNW),
    .OPB_select       (OPB_select),
    .OPB_seqAddr      (OPB_seqAddr),
    .Sl_DBus          (Sl_DBus),
    .Sl_xferAck       (Sl_xferAck),
    .Sl_errAck        (Sl_errAck),
    .Sl_retry         (Sl_retry),
    .Sl_toutSup       (Sl_toutSup),
    .user_data_out    (user_data_out),
    .user_data_strobe (user_data_strobe)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Bench-side byte merge: BE bit 3 (OPB BE[0]) owns the top byte.
  function automatic logic [31:0] model_merge(input logic [31:0] o, input logic [31:0] d,
                                              input logic [3:0] be);
    logic [31:0] m;
    m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (o & ~m) | (d & m);
  endfunction

  always @(negedge clk) begin
    if (Sl_xferAck) ack_cnt++;
    if (user_data_strobe) strobe_cnt++;
    if (mon_en && !Sl_xferAck) chk("dbus_idle_zero", Sl_DBus, 32'h0);
  end

  task automatic xfer(input logic [31:0] addr, input logic rnw, input logic [3:0] be,
                      input logic [31:0] data, input int hold);
    logic hit, wr_ctrl;
    int a0, s0, first;
    logic [31:0] exp, new_ctrl;
    hit = (addr >= BASE) && (addr <= HIGH);
    wr_ctrl = hit && !rnw && !addr[2];
    new_ctrl = wr_ctrl ? model_merge(m_ctrl, data, be) : m_ctrl;
    a0 = ack_cnt; s0 = strobe_cnt; first = -1;
    @(negedge clk);
    OPB_ABus = addr; OPB_BE = be; OPB_DBus = data; OPB_RNW = rnw; OPB_select = 1'b1;
    if (rnw && hit) sb.push_back(addr[2] ? m_wcnt : m_ctrl);
    for (int k = 1; k <= hold; k++) begin
      @(negedge clk);
      if (Sl_xferAck) begin
        if (first < 0) first = k;
        if (rnw && sb.size() > 0) begin
          exp = sb.pop_front();
          chk("rdata", Sl_DBus, exp);
        end
      end
      if (wr_ctrl && first > 0 && k == first + 1) begin
        chk("strobe_cycle2", {31'h0, user_data_strobe}, 32'h1);
        chk("udo_cycle2", user_data_out, new_ctrl);
      end
    end
    OPB_select = 1'b0; OPB_RNW = 1'b1; OPB_BE = 4'h0; OPB_DBus = 32'h0; OPB_ABus = 32'h0;
    if (hit && !rnw) begin
      if (!addr[2]) begin
        m_ctrl = new_ctrl;
        if (m_wcnt != 32'hFFFFFFFF) m_wcnt = m_wcnt + 32'h1;
      end else begin
        m_wcnt = 32'h0;
      end
    end
    @(negedge clk);
    chk("ack_count", ack_cnt - a0, hit ? 32'h1 : 32'h0);
    if (hit) chk("ack_latency", first, 32'h1);
    chk("strobe_count", strobe_cnt - s0, wr_ctrl ? 32'h1 : 32'h0);
    chk("user_data", user_data_out, m_ctrl);
    if (rnw && hit) chk("sb_drained", sb.size(), 32'h0);
  endtask

  initial begin
    m_ctrl = INIT;
    m_wcnt = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_ack", {31'h0, Sl_xferAck}, 32'h0);
    chk("rst_dbus", Sl_DBus, 32'h0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_udo", user_data_out, INIT);
    chk("rst_strobe", {31'h0, user_data_strobe}, 32'h0);
    chk("tieoffs", {29'h0, Sl_errAck, Sl_retry, Sl_toutSup}, 32'h0);

    xfer(BASE,         1'b1, 4'hF, 32'h0, 2);
    xfer(BASE + 32'h4, 1'b1, 4'hF, 32'h0, 2);
    xfer(BASE,         1'b0, 4'hF, 32'h12345678, 2);
    xfer(BASE + 32'h4, 1'b1, 4'hF, 32'h0, 2);
    xfer(BASE,         1'b0, 4'b0101, 32'hAABBCCDD, 2);
    xfer(BASE,         1'b1, 4'hF, 32'h0, 2);
    chk("merge_0101", m_ctrl, 32'h12BB56DD);
    // Long select hold, twice, then aliased reads of both words.
    xfer(BASE,         1'b0, 4'b1100, 32'h0F0F0000, 10);
    xfer(BASE + 32'h4, 1'b1, 4'hF, 32'h0, 2);
    xfer(BASE,         1'b0, 4'b0010, 32'h00009900, 10);
    xfer(BASE + 32'h8, 1'b1, 4'hF, 32'h0, 2);
    xfer(HIGH - 32'h3, 1'b1, 4'hF, 32'h0, 2);

    // Counter saturation, then clear through offset 0x4.
    @(negedge clk);
    force dut.wcnt_r = 32'hFFFFFFFE;
    #1 release dut.wcnt_r;
    m_wcnt = 32'hFFFFFFFE;
    xfer(BASE, 1'b0, 4'hF, 32'hCAFEF00D, 2);
    xfer(BASE, 1'b0, 4'h1, 32'h000000EE, 2);
    xfer(BASE + 32'h4, 1'b1, 4'hF, 32'h0, 2);
    chk("wcnt_sat", m_wcnt, 32'hFFFFFFFF);
    xfer(BASE + 32'h4, 1'b0, 4'hF, 32'h5A5A5A5A, 2);
    xfer(BASE + 32'h4, 1'b1, 4'hF, 32'h0, 2);
    xfer(BASE,         1'b1, 4'hF, 32'h0, 2);

    // Reset arriving during the ACK cycle of a write.
    @(negedge clk);
    OPB_ABus = BASE; OPB_BE = 4'hF; OPB_DBus = 32'hDEADBEEF; OPB_RNW = 1'b0; OPB_select = 1'b1;
    @(negedge clk);
    chk("midack_ack", {31'h0, Sl_xferAck}, 32'h1);
    #1 rst_n = 1'b0;
    #1 chk("rst_async_ack", {31'h0, Sl_xferAck}, 32'h0);
    chk("rst_async_udo", user_data_out, INIT);
    chk("rst_async_wcnt", dut.wcnt_r, 32'h0);
    OPB_select = 1'b0; OPB_RNW = 1'b1;
    m_ctrl = INIT; m_wcnt = 32'h0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    xfer(BASE,         1'b1, 4'hF, 32'h0, 2);
    xfer(BASE + 32'h4, 1'b1, 4'hF, 32'h0, 2);
    xfer(HIGH + 32'h1, 1'b1, 4'hF, 32'h0, 4);
    xfer(BASE - 32'h4, 1'b0, 4'hF, 32'h11111111, 4);
    xfer(BASE + 32'h4, 1'b1, 4'hF, 32'h0, 2);

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
